reg_wb_arbiter: RTL
===================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 5, register address width; DATA_W, 32, register data width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req0_addr / req0_data  input  1 / ADDR_W / DATA_W  writeback source 0 (ALU) request.
REQ-005 req0_ready  output  1  source 0 accepted this cycle.
REQ-006 req1_valid / req1_addr / req1_data  input  1 / ADDR_W / DATA_W  writeback source 1 (load unit) request.
REQ-007 req1_ready  output  1  source 1 accepted this cycle.
REQ-008 issue_valid / issue_rd  input  1 / ADDR_W  instruction issued that will write issue_rd.
REQ-009 wen / regWAddr / regWData  output  1 / ADDR_W / DATA_W  registered write port to the register file.
REQ-010 busy  output  2^ADDR_W  scoreboard; bit n set = write to register n pending.
REQ-011 conflict_cnt  output  16  saturating count of cycles with both requests valid.

Function
REQ-012 A request SHALL be accepted (handshake) in the cycle where its valid and ready are both high; at most one acceptance per cycle.
REQ-013 reqN_ready SHALL be combinational from the valids and arbiter state; a lone valid request SHALL be granted in the same cycle.
REQ-014 On acceptance of a request with nonzero address, wen SHALL be 1 in the next cycle with regWAddr/regWData equal to the accepted address/data (latency 1).
REQ-015 A request with address 0 SHALL be accepted normally but SHALL NOT assert wen; regWAddr/regWData hold their prior values.
REQ-016 In any cycle without a nonzero-address acceptance, wen SHALL be 0 in the next cycle.
REQ-017 issue_valid with issue_rd != 0 SHALL set busy[issue_rd] in the next cycle.
REQ-018 Acceptance of a nonzero-address request SHALL clear busy[addr] in the next cycle.
REQ-019 Simultaneous set and clear of the same bit SHALL leave it set (new producer wins).
REQ-020 busy[0] SHALL always be 0.
REQ-021 Register last_grant (1 bit) SHALL record the source of the most recent acceptance and update only on acceptance.
REQ-022 conflict_cnt SHALL increment each cycle both valids are high and saturate at 16'hFFFF.
REQ-023 A request not granted SHALL keep its ready low; the requester holds valid/addr/data until accepted.

Reset
REQ-024 When reset is high at a clock edge, next-cycle values SHALL be: wen=0, regWAddr=0, regWData=0, busy=0, conflict_cnt=0, last_grant=1.
REQ-025 Requests and issues presented in a reset cycle SHALL be discarded; ready outputs MAY be high but SHALL have no effect.

Configuration
REQ-026 With macro WB_RR_ARB_EN defined, a cycle with both valids SHALL grant the source opposite to last_grant (round-robin).
REQ-027 Without WB_RR_ARB_EN, a cycle with both valids SHALL always grant source 0 (fixed priority); last_grant is still maintained.

Verification
REQ-028 Reset, then req0 valid addr=5 data=32'hDEADBEEF -> req0_ready=1 same cycle; next cycle wen=1, regWAddr=5, regWData=32'hDEADBEEF.
REQ-029 issue_valid rd=7, then req1 addr=7 accepted two cycles later -> busy[7]=1 after issue, busy[7]=0 cycle after acceptance; same-cycle issue rd=7 and accept addr=7 -> busy[7] stays 1.
REQ-030 Both valids held 4 cycles after reset (WB_RR_ARB_EN) -> grants 0,1,0,1; conflict_cnt=4 (until requesters drop); without macro -> source 0 granted every cycle, req1_ready=0.
REQ-031 req0 addr=0 data=32'h1 -> req0_ready=1, next cycle wen=0; issue_valid rd=0 -> busy stays 0.
REQ-032 Assert reset mid-stream with busy=32'h0000_00F0 and pending grants -> next cycle busy=0, wen=0, conflict_cnt=0; first post-reset conflict grants source 0.
REQ-033 Force both valids 70000 cycles -> conflict_cnt saturates at 16'hFFFF without wrapping.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
`timescale 1ns/1ps
// reg_wb_arbiter: two-source writeback arbiter for a register file, with a
// pending-write scoreboard and a saturating conflict counter.
// Optional feature: define WB_RR_ARB_EN for round-robin arbitration on
// conflicts; without it source 0 (ALU) always wins a conflict.
// Address 0 is the hardwired zero register: it is accepted but never written
// and never tracked as busy.
module reg_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic [ADDR_W-1:0]        req0_addr,
    input  logic [DATA_W-1:0]        req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDR_W-1:0]        req1_addr,
    input  logic [DATA_W-1:0]        req1_data,
    output logic                     req1_ready,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_rd,
    output logic                     wen,
    output logic [ADDR_W-1:0]        regWAddr,
    output logic [DATA_W-1:0]        regWData,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic [15:0]              conflict_cnt
);

    localparam int NREG = 1 << ADDR_W;

    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NREG-1:0]     busy_q, busy_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;

    logic                both_v;
    logic                pick1_on_conflict;
    logic                accept;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_data;
    logic                acc_write;
    logic [NREG-1:0]     set_vec;
    logic [NREG-1:0]     clr_vec;

    // Grant selection: a lone request always wins; conflicts resolved by policy.
    always_comb begin
        both_v = req0_valid & req1_valid;
`ifdef WB_RR_ARB_EN
        pick1_on_conflict = ~last_grant_q;
`else
        // Fixed priority ignores history; last_grant is still tracked.
        pick1_on_conflict = 1'b0 & ~last_grant_q;
`endif
        req0_ready = req0_valid & ~(both_v & pick1_on_conflict);
        req1_ready = req1_valid & (~req0_valid | pick1_on_conflict);
        accept     = req0_ready | req1_ready;
        acc_addr   = req1_ready ? req1_addr : req0_addr;
        acc_data   = req1_ready ? req1_data : req0_data;
        acc_write  = accept & (acc_addr != '0);
    end

    // Next-state for write port, scoreboard, conflict counter and grant history.
    always_comb begin
        wen_d        = acc_write;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        if (acc_write) begin
            waddr_d = acc_addr;
            wdata_d = acc_data;
        end

        set_vec = '0;
        clr_vec = '0;
        if (issue_valid) set_vec[issue_rd] = 1'b1;
        if (acc_write)   clr_vec[acc_addr] = 1'b1;
        // Set applied after clear so a new producer wins over a retiring one.
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;

        cnt_d = cnt_q;
        if (both_v && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;

        last_grant_d = accept ? req1_ready : last_grant_q;
    end

    // State registers with synchronous reset; reset cycles discard all traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            busy_q       <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign wen          = wen_q;
    assign regWAddr     = waddr_q;
    assign regWData     = wdata_q;
    assign busy         = busy_q;
    assign conflict_cnt = cnt_q;

endmodule
